// File: rtl/pio_pulse_pkg.sv
// pio_pulse_pkg
//   Shared constants and types for the PIO-driven pulse/PWM generator.
//   PULSE_WIDTH : default width of one period/decode word (PIO export width)
//   MIN_PERIOD  : smallest legal period in cycles; anything below parks a channel
//   pulse_state_t : per-channel FSM encoding
package pio_pulse_pkg;

  localparam int PULSE_WIDTH = 28;
  localparam int MIN_PERIOD  = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } pulse_state_t;

endpackage : pio_pulse_pkg

// File: rtl/pio_pulse_channel.sv
// pio_pulse_channel
//   One independent pulse/PWM channel. Counts a programmable period and holds
//   pulse_out high for the first `decode` cycles of every period. Period and
//   decode are shadowed and only reloaded at a period boundary, so software
//   writes mid-period never produce runt pulses.
//
// Ports
//   clk        : system clock
//   rst        : synchronous, active-high reset
//   enable     : run enable, sampled directly (same clock domain as the PIO)
//   period_in  : requested period in cycles (>= MIN_PERIOD to run)
//   decode_in  : requested high time in cycles
//   pulse_out  : registered pulse output
//   wrap       : one-cycle strobe in the first cycle of each new period
//   active     : channel is in RUN
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | parked; outputs low, waiting for enable with a legal period
// ST_RUN  | counting cnt 0..sh_period-1, pulse high while cnt < sh_decode
module pio_pulse_channel
  import pio_pulse_pkg::*;
#(
  parameter int WIDTH = PULSE_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] period_in,
  input  logic [WIDTH-1:0] decode_in,
  output logic             pulse_out,
  output logic             wrap,
  output logic             active
);

  localparam logic [WIDTH-1:0] MIN_P = WIDTH'(MIN_PERIOD);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  pulse_state_t     state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_period_q, sh_period_d;
  logic [WIDTH-1:0] sh_decode_q, sh_decode_d;
  logic             pulse_q, pulse_d;
  logic             wrap_q, wrap_d;

  logic [WIDTH-1:0] last_cnt;
  logic             at_last;
  logic             period_ok;

  // Guard the decrement: the shadow can legitimately hold 0/1 while idle
  // (after reset, or after a boundary that loaded an illegal period).
  assign last_cnt  = (sh_period_q >= MIN_P) ? (sh_period_q - ONE) : '0;
  assign at_last   = (cnt_q == last_cnt);
  assign period_ok = (period_in >= MIN_P);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_period_d = sh_period_q;
    sh_decode_d = sh_decode_q;
    pulse_d     = 1'b0;
    wrap_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable && period_ok) begin
          state_d     = ST_RUN;
          sh_period_d = period_in;
          sh_decode_d = decode_in;
          cnt_d       = '0;
          pulse_d     = (decode_in != '0);
        end
      end

      ST_RUN: begin
        // Enable loss wins over the boundary: no wrap strobe on that edge.
        if (!enable) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (at_last) begin
          cnt_d       = '0;
          wrap_d      = 1'b1;
          sh_period_d = period_in;
          sh_decode_d = decode_in;
          if (!period_ok) begin
            state_d = ST_IDLE;
          end else begin
            pulse_d = (decode_in != '0);
          end
        end else begin
          cnt_d   = cnt_q + ONE;
          pulse_d = (cnt_d < sh_decode_q);
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      sh_period_q <= '0;
      sh_decode_q <= '0;
      pulse_q     <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_period_q <= sh_period_d;
      sh_decode_q <= sh_decode_d;
      pulse_q     <= pulse_d;
      wrap_q      <= wrap_d;
    end
  end

  assign pulse_out = pulse_q;
  assign wrap      = wrap_q;
  assign active    = (state_q == ST_RUN);

endmodule : pio_pulse_channel

// File: rtl/pio_pulse_gen.sv
// pio_pulse_gen
//   Multi-channel pulse/PWM generator fed by Nios II PIO period/decode words.
//   Splits the packed PIO buses and instantiates one pio_pulse_channel per
//   channel; channels share nothing but clock and reset.
//
// Ports
//   clk_clk     : system clock
//   reset_reset : synchronous, active-high reset
//   period_in   : CHANNELS packed periods, channel n at [n*WIDTH +: WIDTH]
//   decode_in   : CHANNELS packed high times, same packing
//   enable      : per-channel run enable
//   pulse_out   : per-channel registered pulse output
//   wrap        : per-channel period-boundary strobe
//   active      : per-channel RUN indication
module pio_pulse_gen
  import pio_pulse_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = PULSE_WIDTH
) (
  input  logic                      clk_clk,
  input  logic                      reset_reset,
  input  logic [CHANNELS*WIDTH-1:0] period_in,
  input  logic [CHANNELS*WIDTH-1:0] decode_in,
  input  logic [CHANNELS-1:0]       enable,
  output logic [CHANNELS-1:0]       pulse_out,
  output logic [CHANNELS-1:0]       wrap,
  output logic [CHANNELS-1:0]       active
);

  for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
    pio_pulse_channel #(
      .WIDTH (WIDTH)
    ) u_ch (
      .clk       (clk_clk),
      .rst       (reset_reset),
      .enable    (enable[n]),
      .period_in (period_in[n*WIDTH +: WIDTH]),
      .decode_in (decode_in[n*WIDTH +: WIDTH]),
      .pulse_out (pulse_out[n]),
      .wrap      (wrap[n]),
      .active    (active[n])
    );
  end

endmodule : pio_pulse_gen

// File: tb/tb_pio_pulse_gen.sv
// tb_pio_pulse_gen
//   Directed bench for pio_pulse_gen (4 channels x 28 bits). Inputs change
//   1 time unit after a rising edge and outputs are checked at the same point,
//   so each check sees the result of the edge just taken.
module tb_pio_pulse_gen;

  localparam int CH = 4;
  localparam int W  = 28;

  logic            clk_clk = 1'b0;
  logic            reset_reset;
  logic [CH*W-1:0] period_in;
  logic [CH*W-1:0] decode_in;
  logic [CH-1:0]   enable;
  logic [CH-1:0]   pulse_out;
  logic [CH-1:0]   wrap;
  logic [CH-1:0]   active;

  int n_vec = 0;
  int n_err = 0;

  pio_pulse_gen #(.CHANNELS(CH), .WIDTH(W)) dut (
    .clk_clk     (clk_clk),
    .reset_reset (reset_reset),
    .period_in   (period_in),
    .decode_in   (decode_in),
    .enable      (enable),
    .pulse_out   (pulse_out),
    .wrap        (wrap),
    .active      (active)
  );

  always #5 clk_clk = ~clk_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic set_ch(input int n, input logic [W-1:0] p, input logic [W-1:0] d, input logic en);
    period_in[n*W +: W] = p;
    decode_in[n*W +: W] = d;
    enable[n]           = en;
  endtask

  task automatic do_reset();
    reset_reset = 1'b1;
    tick();
    reset_reset = 1'b0;
  endtask

  initial begin
    reset_reset = 1'b1;
    period_in   = '0;
    decode_in   = '0;
    enable      = '0;
    tick();
    tick();
    chk("rst_pulse", 32'(pulse_out), 32'h0);
    chk("rst_wrap", 32'(wrap), 32'h0);
    chk("rst_active", 32'(active), 32'h0);
    reset_reset = 1'b0;

    // Basic PWM: ch0 period 10, decode 3
    set_ch(0, 28'd10, 28'd3, 1'b1);
    for (int i = 0; i < 30; i++) begin
      tick();
      chk($sformatf("pwm_pulse[%0d]", i), 32'(pulse_out[0]), 32'((i % 10) < 3));
      chk($sformatf("pwm_wrap[%0d]", i), 32'(wrap[0]), 32'(i > 0 && (i % 10) == 0));
      chk($sformatf("pwm_active[%0d]", i), 32'(active[0]), 32'h1);
    end

    // Reset in the middle of a run, then a fresh restart
    tick();
    tick();
    do_reset();
    chk("midrst_pulse", 32'(pulse_out), 32'h0);
    chk("midrst_wrap", 32'(wrap), 32'h0);
    chk("midrst_active", 32'(active), 32'h0);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk($sformatf("restart_pulse[%0d]", i), 32'(pulse_out[0]), 32'((i % 10) < 3));
      chk($sformatf("restart_wrap[%0d]", i), 32'(wrap[0]), 32'(i > 0 && (i % 10) == 0));
    end
    set_ch(0, 28'd0, 28'd0, 1'b0);
    tick();
    chk("stop_ch0_active", 32'(active[0]), 32'h0);

    // Glitch-free update: ch1 8/4, rewritten to 5/1 at cnt=3
    set_ch(1, 28'd8, 28'd4, 1'b1);
    for (int i = 0; i < 23; i++) begin
      tick();
      chk($sformatf("upd_pulse[%0d]", i), 32'(pulse_out[1]),
          32'((i < 8) ? (i < 4) : (((i - 8) % 5) == 0)));
      chk($sformatf("upd_wrap[%0d]", i), 32'(wrap[1]), 32'(i >= 8 && ((i - 8) % 5) == 0));
      chk($sformatf("upd_ch0_quiet[%0d]", i), 32'(pulse_out[0]), 32'h0);
      if (i == 3) set_ch(1, 28'd5, 28'd1, 1'b1);
    end
    set_ch(1, 28'd0, 28'd0, 1'b0);
    tick();

    // Extremes: ch0 decode=0, ch3 decode=period=12, ch2 period=1
    set_ch(0, 28'd4, 28'd0, 1'b1);
    set_ch(2, 28'd1, 28'd0, 1'b1);
    set_ch(3, 28'd12, 28'd12, 1'b1);
    for (int i = 0; i < 26; i++) begin
      tick();
      chk($sformatf("d0_pulse[%0d]", i), 32'(pulse_out[0]), 32'h0);
      chk($sformatf("d0_wrap[%0d]", i), 32'(wrap[0]), 32'(i > 0 && (i % 4) == 0));
      chk($sformatf("d0_active[%0d]", i), 32'(active[0]), 32'h1);
      chk($sformatf("p1_active[%0d]", i), 32'(active[2]), 32'h0);
      chk($sformatf("p1_pulse[%0d]", i), 32'(pulse_out[2]), 32'h0);
      chk($sformatf("full_pulse[%0d]", i), 32'(pulse_out[3]), 32'h1);
      chk($sformatf("full_wrap[%0d]", i), 32'(wrap[3]), 32'(i > 0 && (i % 12) == 0));
    end
    enable = '0;
    tick();
    chk("ext_stop_active", 32'(active), 32'h0);

    // Enable drop mid-period: ch2 period 6, decode 3, drop at cnt=4
    set_ch(2, 28'd6, 28'd3, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("drop_pulse[%0d]", i), 32'(pulse_out[2]), 32'(i < 3));
    end
    enable[2] = 1'b0;
    tick();
    chk("drop_pulse_off", 32'(pulse_out[2]), 32'h0);
    chk("drop_active_off", 32'(active[2]), 32'h0);
    chk("drop_wrap_off", 32'(wrap[2]), 32'h0);

    // Enable drop on the boundary edge: no wrap
    enable[2] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("coll_pulse[%0d]", i), 32'(pulse_out[2]), 32'(i < 3));
    end
    enable[2] = 1'b0;
    tick();
    chk("coll_wrap", 32'(wrap[2]), 32'h0);
    chk("coll_active", 32'(active[2]), 32'h0);
    chk("coll_pulse_off", 32'(pulse_out[2]), 32'h0);
    tick();
    chk("coll_wrap_after", 32'(wrap[2]), 32'h0);

    // Illegal period picked up at a boundary: wrap pulses, channel parks
    set_ch(2, 28'd4, 28'd2, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("bad_pulse[%0d]", i), 32'(pulse_out[2]), 32'(i < 2));
      chk($sformatf("bad_active[%0d]", i), 32'(active[2]), 32'h1);
      if (i == 1) set_ch(2, 28'd1, 28'd2, 1'b1);
    end
    tick();
    chk("bad_wrap", 32'(wrap[2]), 32'h1);
    chk("bad_active_off", 32'(active[2]), 32'h0);
    chk("bad_pulse_off", 32'(pulse_out[2]), 32'h0);
    tick();
    chk("bad_wrap_once", 32'(wrap[2]), 32'h0);
    chk("bad_stays_idle", 32'(active[2]), 32'h0);
    enable = '0;

    // Independence: periods 2, 3, 1000, 2^28-1 with decode = period/2
    do_reset();
    set_ch(0, 28'd2, 28'd1, 1'b1);
    set_ch(1, 28'd3, 28'd1, 1'b1);
    set_ch(2, 28'd1000, 28'd500, 1'b1);
    set_ch(3, 28'hFFF_FFFF, 28'h7FF_FFFF, 1'b1);
    for (int i = 0; i < 2010; i++) begin
      tick();
      chk($sformatf("ind0_pulse[%0d]", i), 32'(pulse_out[0]), 32'((i % 2) == 0));
      chk($sformatf("ind0_wrap[%0d]", i), 32'(wrap[0]), 32'(i > 0 && (i % 2) == 0));
      chk($sformatf("ind1_pulse[%0d]", i), 32'(pulse_out[1]), 32'((i % 3) == 0));
      chk($sformatf("ind1_wrap[%0d]", i), 32'(wrap[1]), 32'(i > 0 && (i % 3) == 0));
      chk($sformatf("ind2_pulse[%0d]", i), 32'(pulse_out[2]), 32'((i % 1000) < 500));
      chk($sformatf("ind2_wrap[%0d]", i), 32'(wrap[2]), 32'(i > 0 && (i % 1000) == 0));
      chk($sformatf("ind3_pulse[%0d]", i), 32'(pulse_out[3]), 32'h1);
      chk($sformatf("ind3_wrap[%0d]", i), 32'(wrap[3]), 32'h0);
      chk($sformatf("ind_active[%0d]", i), 32'(active), 32'hF);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_pio_pulse_gen
